// File: rtl/puf_soc_uart_rx.sv
// UART 8N1 receiver that assembles a PUF challenge (mux selects) from N_BYTES serial bytes,
// LSB byte first, and presents it via the ready/valid/done handshake.
module puf_soc_uart_rx #(
  parameter int unsigned MUX_LENGTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 868,
  localparam int unsigned DATA_W      = 2 * $clog2(MUX_LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_en,
  input  logic              i_rx_serial,
  output logic              o_rx_ready,
  output logic              o_rx_valid,
  output logic              o_rx_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_frame_err
);

  localparam int unsigned N_BYTES = (DATA_W + 7) / 8;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CntHalf  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIDX_W-1:0] ByteLast = BIDX_W'(N_BYTES - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic              r_sync1, r_sync2;
  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit_idx;
  logic [BIDX_W-1:0] r_byte_idx;
  logic [7:0]        r_shift;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid, r_rx_done, r_frame_err;

  logic              w_rxs;
  logic [2:0]        w_state_d;
  logic [CNT_W-1:0]  w_cnt_d;
  logic [2:0]        w_bit_d;
  logic [BIDX_W-1:0] w_byte_d;
  logic [7:0]        w_shift_d;
  logic              w_valid_d, w_done_d, w_ferr_d, w_store, w_load;

  assign w_rxs = r_sync2;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit_idx;
    w_byte_d  = r_byte_idx;
    w_shift_d = r_shift;
    w_valid_d = r_rx_valid;
    w_done_d  = 1'b0;
    w_ferr_d  = 1'b0;
    w_store   = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (i_rx_en && !w_rxs) w_state_d = StStart;
      end
      StStart: begin
        if (r_cnt == CntHalf) begin
          w_cnt_d = '0;
          if (!w_rxs) begin
            w_state_d = StData;
            w_bit_d   = '0;
            if (r_byte_idx == '0) w_valid_d = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StData: begin
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_shift_d = {w_rxs, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_d = StStop;
          else                   w_bit_d   = r_bit_idx + 3'd1;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StStop: begin
        if (r_cnt == CntLast) begin
          w_cnt_d = '0;
          if (!w_rxs) begin
            w_ferr_d  = 1'b1;
            w_valid_d = 1'b0;
            w_byte_d  = '0;
            w_state_d = StIdle;
          end else begin
            w_store = 1'b1;
            if (r_byte_idx == ByteLast) begin
              w_state_d = StDone;
            end else begin
              w_byte_d  = r_byte_idx + BIDX_W'(1);
              w_state_d = StIdle;
            end
          end
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        w_load    = 1'b1;
        w_done_d  = 1'b1;
        w_valid_d = 1'b0;
        w_byte_d  = '0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_buf       <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_rx_serial;
      r_sync2     <= r_sync1;
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bit_idx   <= w_bit_d;
      r_byte_idx  <= w_byte_d;
      r_shift     <= w_shift_d;
      r_rx_valid  <= w_valid_d;
      r_rx_done   <= w_done_d;
      r_frame_err <= w_ferr_d;
      // Bits of the last byte beyond DATA_W are simply never stored.
      if (w_store) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (r_byte_idx == BIDX_W'(i / 8)) r_buf[i] <= r_shift[i % 8];
        end
      end
      if (w_load) r_rx_data <= r_buf;
    end
  end

  assign o_rx_ready  = (r_state == StIdle) && i_rx_en && (r_byte_idx == '0);
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_done   = r_rx_done;
  assign o_rx_data   = r_rx_data;
  assign o_frame_err = r_frame_err;

endmodule

// File: doc/puf_soc_uart_rx.md
# puf_soc_uart_rx

Serial receiver that deserializes a PUF challenge from a UART line (8N1, LSB first) and presents it to the PUF SoC controller through the `rx_ready` / `rx_valid` / `rx_done` / `rx_data` handshake. The controller consumes these signals in its RECEIVE state. The received challenge word carries the two ring-oscillator mux selects: the upper half is mux 1 and the lower half is mux 0. The block sits between the board-level UART pin and the controller.

## Interface

- `MUX_LENGTH`, 16: ring-oscillator mux depth. `DATA_W = 2*$clog2(MUX_LENGTH)`.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; must be ≥ 4.
- Derived `N_BYTES = ceil(DATA_W/8)`. Bytes are assembled LSB byte first. Unused upper bits of the last byte are discarded.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_en`  in  1  receive enable from the controller; when low, the line is ignored.
- `i_rx_serial`  in  1  asynchronous UART line, idle high.
- `o_rx_ready`  out  1  receiver idle and enabled, waiting for a start bit.
- `o_rx_valid`  out  1  challenge reception in progress.
- `o_rx_done`  out  1  one-cycle pulse: `o_rx_data` is updated this cycle.
- `o_rx_data`  out  DATA_W  last complete challenge; held until the next `o_rx_done`.
- `o_frame_err`  out  1  one-cycle pulse: stop bit was sampled low and the challenge is discarded.

## Operation

- `i_rx_serial` passes through a 2-flop synchronizer; all sampling uses the synchronized value `rxs`.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. The bit index counts 0..7. The byte index counts 0..N_BYTES-1.
- FSM states: IDLE, START, DATA, STOP, DONE.
  - **IDLE:** go to START when `i_rx_en` is high and `rxs` is 0.
  - **START:** at count `CLKS_PER_BIT/2-1`, resample `rxs`. If it is 0, go to DATA and clear the counter. If it is 1 (glitch), return to IDLE with no outputs.
  - **DATA:** sample `rxs` every `CLKS_PER_BIT` cycles (mid-bit) and shift it into the byte register LSB first. After bit 7, go to STOP.
  - **STOP:** sample at mid-bit.
    - 0: pulse `o_frame_err`, clear the byte index, go to IDLE.
    - 1, and this is not the last byte: store the byte, increment the byte index, go to IDLE to wait for the next start bit.
    - 1, and this is the last byte: go to DONE.
  - **DONE:** load `o_rx_data` from the assembled bytes, pulse `o_rx_done`, clear the byte index, go to IDLE.
- `o_rx_ready` = (state == IDLE) & `i_rx_en` & (byte index == 0).
- `o_rx_valid` is registered. It rises on the cycle START confirms the first byte's start bit. It falls on the `o_rx_done` cycle or the `o_frame_err` cycle.
- `i_rx_en` falling mid-frame does not abort the frame. The current challenge completes, then the block stays in IDLE until `i_rx_en` returns.
- After a frame error, `o_rx_data` keeps its previous value.

## Timing

- Reset values: state IDLE, counters 0, synchronizer flops 1.
  - `o_rx_data` = 0; `o_rx_valid`, `o_rx_done`, `o_frame_err` = 0.
  - `o_rx_ready` = `i_rx_en` from the first cycle after reset.
- `rst` asserted in any state forces reset values on the next edge. A partial challenge is lost and no done or error pulse is produced.
- Latency, start-bit falling edge on the pin to START entry: 3 cycles (2 synchronizer stages plus IDLE detection).
- The start bit is confirmed `CLKS_PER_BIT/2` cycles after START entry. Data bit k is sampled `(k+1)*CLKS_PER_BIT` cycles after confirmation. The stop bit is sampled `9*CLKS_PER_BIT` cycles after confirmation.
- `o_rx_done` is asserted exactly 1 cycle after the last stop-bit sample and lasts exactly 1 cycle. `o_rx_data` changes on that same edge.
- Back-to-back frames (stop bit immediately followed by a start bit) are accepted. IDLE is re-entered before the next start bit's mid-point.
- The line held low in IDLE (break) restarts START repeatedly. Each pass fails at STOP, giving `o_frame_err` once per frame period.

## Test plan

Run all scenarios with `CLKS_PER_BIT=4` and `MUX_LENGTH=16` (`DATA_W=8`, `N_BYTES=1`) unless noted.

- **Normal frame:** reset 5 cycles, `i_rx_en=1`, send 0xA5 as 8N1.
  - `o_rx_ready` is 1 before the start bit and 0 during the frame.
  - `o_rx_valid` is high from start confirmation until done.
  - One `o_rx_done` pulse; `o_rx_data=0xA5`, i.e. mux 1 = 0xA, mux 0 = 0x5.
- **Glitch rejection:** drive the line low for 1 cycle only. No `o_rx_valid`, no `o_rx_done`; state returns to IDLE; `o_rx_data` unchanged.
- **Frame error:** send 0x3C with the stop bit forced to 0. One `o_frame_err` pulse, no `o_rx_done`, `o_rx_data` keeps 0xA5; the next good frame 0x12 gives `o_rx_data=0x12`.
- **Enable gating and reset mid-frame:**
  - With `i_rx_en=0`, send 0x77: no activity and `o_rx_ready=0`.
  - Then set `i_rx_en=1`, start sending 0x77, and assert `rst` after bit 3: all outputs return to 0 and no done pulse occurs.
- **Multi-byte and back-to-back:** `MUX_LENGTH=512` (`DATA_W=18`, `N_BYTES=3`); send bytes 0x34, 0x12, 0xFF with no idle gap.
  - `o_rx_valid` stays high across all three frames.
  - A single `o_rx_done` pulse with `o_rx_data=18'h31234`.
